ram_port_master: RTL and testbench
==================================

Name: ram_port_master

Overview:
- Initiator for the team's single-port read-first RAM.
- Accepts read/write requests on a valid/ready interface and drives the RAM port pins.
- Tracks the RAM read latency and returns read data on a backpressurable valid/ready response channel through a small response FIFO.
- Also provides a clear sequencer that sweeps the whole RAM to zero on request.

Parameters:
- RAM_WIDTH, 8, data width; must match the attached RAM.
- RAM_DEPTH, 256, number of entries; address width AW = $clogb2(RAM_DEPTH).
- RAM_LATENCY, 2, read latency of the attached RAM in clocks: 1 = LOW_LATENCY, 2 = HIGH_PERFORMANCE. Any other value is illegal.
- RSP_DEPTH, 4, response FIFO entries; must be at least 2.

Ports:
- clka  in  1  clock
- rsta_n  in  1  asynchronous active-low reset
- req_valid  in  1  request valid
- req_ready  out  1  request ready
- req_we  in  1  1 = write, 0 = read
- req_addr  in  AW  request address
- req_wdata  in  RAM_WIDTH  write data
- rsp_valid  out  1  read response valid
- rsp_ready  in  1  response consumer ready
- rsp_rdata  out  RAM_WIDTH  read data
- clr_start  in  1  single-cycle pulse; starts the clear sweep
- busy  out  1  clear sweep in progress
- ram_addra  out  AW  to RAM addra
- ram_dina  out  RAM_WIDTH  to RAM dina
- ram_wea  out  1  to RAM wea
- ram_ena  out  1  to RAM ena
- ram_rsta  out  1  to RAM rsta; constant 0
- ram_regcea  out  1  to RAM regcea; constant 1
- ram_douta  in  RAM_WIDTH  from RAM douta

Behaviour:
- Reset (rsta_n low, asynchronous):
  - FSM to IDLE; busy = 0; rsp_valid = 0; FIFO empty; in-flight pipeline cleared; clear address = 0.
  - All ram_* control outputs 0, except ram_regcea = 1.
- FSM states:
  - IDLE: req_ready is high when a read can be credited. A write request is accepted whenever the FSM is in IDLE.
  - IDLE -> CLEAR when clr_start = 1. clr_start has priority over a same-cycle request; that request is not accepted.
  - CLEAR: req_ready = 0, busy = 1. Each cycle drives ram_ena = 1, ram_wea = 1, ram_dina = 0, ram_addra = clr_addr; clr_addr increments.
  - CLEAR -> IDLE after writing address RAM_DEPTH-1, i.e. exactly RAM_DEPTH cycles in CLEAR. clr_addr wraps to 0. clr_start during CLEAR is ignored.
- Request issue:
  - RAM outputs are combinational from the accept: ram_ena = req_valid & req_ready; ram_wea = ram_ena & req_we; ram_addra = req_addr; ram_dina = req_wdata.
  - When not issuing and not in CLEAR: ram_ena = 0, ram_wea = 0. Address and data outputs are don't-care but must be stable, so hold the last values.
- Writes produce no response. The RAM's read-first old data from a write is discarded.
- Read tracking:
  - A shift register of RAM_LATENCY valid bits.
  - A read accepted at edge k is captured from ram_douta into the FIFO at edge k+RAM_LATENCY.
  - rsp_valid rises in the cycle after that edge, at the earliest.
  - Clear writes inject 0 into the shift register.
- Credit rule: a read is accepted only if (reads in flight + FIFO occupancy) < RSP_DEPTH. This guarantees FIFO pushes never overflow. A pop in the same cycle is not counted toward freeing credit (conservative).
- Response FIFO:
  - First-word-fall-through: rsp_rdata is valid whenever rsp_valid = 1.
  - rsp_valid and rsp_rdata are held stable until rsp_ready.
  - Simultaneous push and pop is legal at any occupancy, including full, and keeps the count unchanged.
  - Pointers wrap modulo RSP_DEPTH.
- Ordering: responses are returned in request order.
- Read-after-write to the same address on consecutive accepts returns the new data (the RAM write lands before the later read).
- In-flight reads complete normally across a CLEAR start; their data reflects contents at the time of issue.
- Reset mid-operation: in-flight reads and FIFO contents are discarded and no response is produced. RAM contents are not touched.

Test Plan:
- Reset, write addr 0x10 = 0xA5, then read 0x10 (RAM_LATENCY=2) -> rsp_valid rises exactly 3 cycles after the read-accept cycle with rsp_rdata = 0xA5; no response for the write.
- Back-to-back writes 0x00..0x07 = addr^0x3C, then 8 back-to-back reads with rsp_ready held 0 -> req_ready drops after 4 reads accepted. Release rsp_ready -> data 0x3C, 0x3D, 0x3E, 0x3F, ... returned in order with no loss or duplication.
- Random rsp_ready toggling with continuous reads, RAM_LATENCY = 1 and 2 -> FIFO never overflows, all data matches the scoreboard, and push+pop at full is exercised.
- Write 0x20 = 0x11 on cycle n, read 0x20 on cycle n+1 -> response 0x11.
- Fill 4 addresses with 0xFF, pulse clr_start together with a pending read -> read is not accepted that cycle; busy is high for exactly 256 cycles; reads of those addresses afterwards return 0x00.
- Assert rsta_n low with 2 reads in flight and 1 FIFO entry -> rsp_valid = 0 immediately. After release: no stale responses, busy = 0, req_ready = 1.

Source files
------------

// File: rtl/ram_port_master.sv
// ram_port_master: request initiator for a single-port read-first RAM.
// Requests arrive on req_* (valid/ready) and drive the ram_* pins combinationally.
// Reads come back in order on rsp_* through a first-word-fall-through FIFO.
// Reads are credited so that the FIFO can never overflow.
// clr_start starts a sweep that writes zero to every address; busy is high during the sweep.
// Ports: clka/rsta_n are the clock and the async active-low reset.
//   req_*: request channel. rsp_*: response channel.
//   clr_start/busy: clear sweep control. ram_*: RAM port pins.
module ram_port_master #(
   parameter int RAM_WIDTH   = 8,
   parameter int RAM_DEPTH   = 256,
   parameter int RAM_LATENCY = 2,
   parameter int RSP_DEPTH   = 4,
   localparam int AW = $clog2(RAM_DEPTH)
) (
   input  logic                 clka,
   input  logic                 rsta_n,
   input  logic                 req_valid,
   output logic                 req_ready,
   input  logic                 req_we,
   input  logic [AW-1:0]        req_addr,
   input  logic [RAM_WIDTH-1:0] req_wdata,
   output logic                 rsp_valid,
   input  logic                 rsp_ready,
   output logic [RAM_WIDTH-1:0] rsp_rdata,
   input  logic                 clr_start,
   output logic                 busy,
   output logic [AW-1:0]        ram_addra,
   output logic [RAM_WIDTH-1:0] ram_dina,
   output logic                 ram_wea,
   output logic                 ram_ena,
   output logic                 ram_rsta,
   output logic                 ram_regcea,
   input  logic [RAM_WIDTH-1:0] ram_douta
);
   localparam int PW = $clog2(RSP_DEPTH);
   localparam int CW = $clog2(RSP_DEPTH + RAM_LATENCY + 1);
   typedef enum logic {IDLE, CLEAR} state_t;
   state_t               state_q, state_d;
   logic [AW-1:0]        clr_addr_q, clr_addr_d, addr_q;
   logic [RAM_WIDTH-1:0] din_q;
   logic [RAM_LATENCY-1:0] pipe_q, pipe_d;
   logic [RAM_LATENCY:0] shift;
   logic [RAM_WIDTH-1:0] fifo_q [RSP_DEPTH];
   logic [PW-1:0]        wr_q, wr_d, rd_q, rd_d;
   logic [CW-1:0]        cnt_q, cnt_d, inflight;
   logic                 clearing, last, credit, issue, push, pop;
   always_comb begin
      inflight = '0;
      for (int i = 0; i < RAM_LATENCY; i++) inflight = inflight + CW'(pipe_q[i]);
   end
   assign clearing   = state_q == CLEAR;
   assign last       = clr_addr_q == AW'(RAM_DEPTH - 1);
   // Pops in the current cycle are deliberately not counted as freed credit.
   assign credit     = (inflight + cnt_q) < CW'(RSP_DEPTH);
   // clr_start wins over a request presented in the same cycle.
   assign req_ready  = !clearing && !clr_start && (req_we || credit);
   assign issue      = req_valid && req_ready;
   assign ram_ena    = issue || clearing;
   assign ram_wea    = clearing || (issue && req_we);
   // When the port is idle, the address and data pins keep their last values.
   assign ram_addra  = clearing ? clr_addr_q : issue ? req_addr : addr_q;
   assign ram_dina   = clearing ? '0 : issue ? req_wdata : din_q;
   assign ram_rsta   = 1'b0;
   assign ram_regcea = 1'b1;
   assign busy       = clearing;
   assign state_d    = clearing ? (last ? IDLE : CLEAR) : (clr_start ? CLEAR : IDLE);
   assign clr_addr_d = !clearing ? clr_addr_q : last ? '0 : clr_addr_q + AW'(1);
   // Read-valid bits age by one position per clock.
   // The oldest bit marks the cycle in which ram_douta holds that read's data.
   assign shift      = {pipe_q, issue && !req_we};
   assign pipe_d     = shift[RAM_LATENCY-1:0];
   assign push       = pipe_q[RAM_LATENCY-1];
   assign rsp_valid  = cnt_q != '0;
   assign rsp_rdata  = fifo_q[rd_q];
   assign pop        = rsp_valid && rsp_ready;
   assign wr_d       = !push ? wr_q : (wr_q == PW'(RSP_DEPTH - 1)) ? '0 : wr_q + PW'(1);
   assign rd_d       = !pop ? rd_q : (rd_q == PW'(RSP_DEPTH - 1)) ? '0 : rd_q + PW'(1);
   assign cnt_d      = cnt_q + CW'(push) - CW'(pop);
   always_ff @(posedge clka or negedge rsta_n) begin
      if (!rsta_n) begin
         state_q    <= IDLE;
         clr_addr_q <= '0;
         addr_q     <= '0;
         din_q      <= '0;
         pipe_q     <= '0;
         wr_q       <= '0;
         rd_q       <= '0;
         cnt_q      <= '0;
      end else begin
         state_q    <= state_d;
         clr_addr_q <= clr_addr_d;
         addr_q     <= ram_addra;
         din_q      <= ram_dina;
         pipe_q     <= pipe_d;
         wr_q       <= wr_d;
         rd_q       <= rd_d;
         cnt_q      <= cnt_d;
      end
   end
   always_ff @(posedge clka) begin
      if (push) fifo_q[wr_q] <= ram_douta;
   end
endmodule

// File: tb/tb_ram_port_master.sv
// tb_ram_port_master: runs the same directed test set against both RAM latencies in parallel.
module tb_ram_port_master;
   localparam int W = 8, D = 256, RD = 4;
   logic clk = 1'b0;
   always #5 clk = ~clk;
   int n_cmp = 0, n_bad = 0;
   task automatic check(input string nm, input logic [31:0] act, input logic [31:0] want);
      n_cmp++;
      if (act !== want) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h", nm, act, want);
      end
   endtask
   initial begin
      #400000;
      $display("FAIL watchdog: got no finish expected finish");
      $fatal(1, "timeout");
   end
   for (genvar g = 0; g < 2; g++) begin : u
      localparam int L = g + 1;
      logic rsta_n, req_valid, req_ready, req_we, rsp_valid, rsp_ready, clr_start, busy;
      logic ram_wea, ram_ena, ram_rsta, ram_regcea, fin, stop;
      logic [7:0] req_addr, req_wdata, rsp_rdata, ram_addra, ram_dina, ram_douta, r1, r2;
      logic [7:0] mem [D];
      logic [7:0] gold [D];
      logic [7:0] exp_q [$];
      int due_q [$];
      logic [7:0] got [$];
      int busy_cnt = 0, cyc = 0;
      ram_port_master #(.RAM_WIDTH(W), .RAM_DEPTH(D), .RAM_LATENCY(L), .RSP_DEPTH(RD)) dut (
         .clka(clk), .rsta_n(rsta_n), .req_valid(req_valid), .req_ready(req_ready),
         .req_we(req_we), .req_addr(req_addr), .req_wdata(req_wdata),
         .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
         .clr_start(clr_start), .busy(busy), .ram_addra(ram_addra), .ram_dina(ram_dina),
         .ram_wea(ram_wea), .ram_ena(ram_ena), .ram_rsta(ram_rsta), .ram_regcea(ram_regcea),
         .ram_douta(ram_douta));
      // Read-first single-port RAM, with an optional output register.
      always @(posedge clk) begin
         if (ram_ena) begin
            r1 <= mem[ram_addra];
            if (ram_wea) mem[ram_addra] <= ram_dina;
         end
         if (ram_regcea) r2 <= r1;
      end
      assign ram_douta = (L == 2) ? r2 : r1;
      // Model: a golden copy of the RAM contents plus a queue of expected responses.
      // Each queued response carries the cycle from which it may appear.
      always @(negedge clk) begin : model
         logic ev, ex_ready;
         cyc++;
         if (!rsta_n) begin
            exp_q.delete();
            due_q.delete();
            busy_cnt = 0;
            check($sformatf("L%0d rst_rsp_valid", L), rsp_valid, 0);
            check($sformatf("L%0d rst_busy", L), busy, 0);
            check($sformatf("L%0d rst_ena", L), ram_ena, 0);
            check($sformatf("L%0d rst_wea", L), ram_wea, 0);
            check($sformatf("L%0d rst_regcea", L), ram_regcea, 1);
            check($sformatf("L%0d rst_rsta", L), ram_rsta, 0);
         end else begin
            ev = exp_q.size() > 0 && due_q[0] <= cyc;
            ex_ready = busy_cnt == 0 && !clr_start && (req_we || exp_q.size() < RD);
            check($sformatf("L%0d rsp_valid@%0d", L, cyc), rsp_valid, ev);
            if (ev) check($sformatf("L%0d rsp_rdata@%0d", L, cyc), rsp_rdata, exp_q[0]);
            check($sformatf("L%0d req_ready@%0d", L, cyc), req_ready, ex_ready);
            check($sformatf("L%0d busy@%0d", L, cyc), busy, busy_cnt > 0);
            if (ev && rsp_ready) begin
               got.push_back(rsp_rdata);
               void'(exp_q.pop_front());
               void'(due_q.pop_front());
            end
            if (busy_cnt > 0) busy_cnt--;
            else if (clr_start) begin
               busy_cnt = D;
               foreach (gold[i]) gold[i] = '0;
            end else if (req_valid && ex_ready) begin
               if (req_we) gold[req_addr] = req_wdata;
               else begin
                  exp_q.push_back(gold[req_addr]);
                  due_q.push_back(cyc + L + 1);
               end
            end
         end
      end
      task automatic step(input int n);
         repeat (n) @(posedge clk);
         #1;
      endtask
      task automatic issue(input logic we, input logic [7:0] a, input logic [7:0] d);
         logic acc;
         req_valid = 1'b1; req_we = we; req_addr = a; req_wdata = d;
         for (int t = 0; ; t++) begin
            @(negedge clk);
            acc = req_ready;
            step(1);
            if (acc) break;
            if (t > 2000) begin
               check($sformatf("L%0d issue_timeout", L), 0, 1);
               break;
            end
         end
         req_valid = 1'b0;
      endtask
      initial begin
         logic [7:0] t2 [8];
         int acc_n, bc;
         t2 = '{8'h3C, 8'h3D, 8'h3E, 8'h3F, 8'h38, 8'h39, 8'h3A, 8'h3B};
         fin = 0; stop = 0;
         rsta_n = 0; req_valid = 0; req_we = 0; req_addr = 0; req_wdata = 0;
         rsp_ready = 1; clr_start = 0;
         for (int i = 0; i < D; i++) begin mem[i] = '0; gold[i] = '0; end
         #1;
         check($sformatf("L%0d init_rsp_valid", L), rsp_valid, 0);
         check($sformatf("L%0d init_busy", L), busy, 0);
         check($sformatf("L%0d init_regcea", L), ram_regcea, 1);
         step(3);
         rsta_n = 1;
         step(1);
         // Single write then read: data appears L+1 cycles after the accept cycle.
         issue(1, 8'h10, 8'hA5);
         issue(0, 8'h10, 8'h00);
         for (int i = 1; i <= L + 1; i++) begin
            @(negedge clk);
            check($sformatf("L%0d lat_valid_%0d", L, i), rsp_valid, i == L + 1);
            if (i == L + 1) check($sformatf("L%0d lat_data", L), rsp_rdata, 8'hA5);
         end
         step(1);
         // Read immediately after a write to the same address.
         got.delete();
         issue(1, 8'h20, 8'h11);
         issue(0, 8'h20, 8'h00);
         step(L + 3);
         check($sformatf("L%0d raw_cnt", L), got.size(), 1);
         check($sformatf("L%0d raw_data", L), got.size() > 0 ? got[0] : 8'hxx, 8'h11);
         // Credit limit with a stalled consumer, then in-order drain.
         for (int i = 0; i < 8; i++) issue(1, 8'(i), 8'(i) ^ 8'h3C);
         got.delete();
         rsp_ready = 0; acc_n = 0;
         req_valid = 1; req_we = 0; req_addr = 0;
         for (int t = 0; t < 10; t++) begin
            @(negedge clk);
            if (req_ready) acc_n++;
            step(1);
            req_addr = 8'(acc_n);
         end
         @(negedge clk);
         check($sformatf("L%0d credit_ready", L), req_ready, 0);
         check($sformatf("L%0d credit_accepts", L), acc_n, 4);
         step(1);
         req_valid = 0;
         rsp_ready = 1;
         for (int i = 4; i < 8; i++) issue(0, 8'(i), 8'h00);
         step(L + 8);
         check($sformatf("L%0d order_cnt", L), got.size(), 8);
         for (int i = 0; i < 8; i++)
            check($sformatf("L%0d order_%0d", L, i), got.size() > i ? got[i] : 8'hxx, t2[i]);
         // Clear sweep wins over a same-cycle read and lasts exactly D cycles.
         for (int i = 0; i < 4; i++) issue(1, 8'h40 + 8'(i), 8'hFF);
         req_valid = 1; req_we = 0; req_addr = 8'h40; clr_start = 1;
         @(negedge clk);
         check($sformatf("L%0d clr_prio_ready", L), req_ready, 0);
         step(1);
         clr_start = 0; req_valid = 0; bc = 0;
         for (int t = 0; t < 1000; t++) begin
            @(negedge clk);
            if (!busy) break;
            bc++;
         end
         check($sformatf("L%0d busy_cycles", L), bc, 256);
         step(1);
         got.delete();
         for (int i = 0; i < 4; i++) issue(0, 8'h40 + 8'(i), 8'h00);
         step(L + 6);
         check($sformatf("L%0d clr_cnt", L), got.size(), 4);
         for (int i = 0; i < 4; i++)
            check($sformatf("L%0d clr_data_%0d", L, i), got.size() > i ? got[i] : 8'hxx, 8'h00);
         // Reset with reads both in flight and queued in the FIFO.
         rsp_ready = 0;
         issue(0, 8'h01, 8'h00);
         issue(0, 8'h02, 8'h00);
         issue(0, 8'h03, 8'h00);
         check($sformatf("L%0d pre_rst_valid", L), rsp_valid, 1);
         got.delete();
         rsta_n = 0;
         #1;
         check($sformatf("L%0d rst_now_valid", L), rsp_valid, 0);
         step(2);
         rsta_n = 1;
         @(negedge clk);
         check($sformatf("L%0d post_rst_ready", L), req_ready, 1);
         check($sformatf("L%0d post_rst_busy", L), busy, 0);
         step(1);
         rsp_ready = 1;
         step(6);
         check($sformatf("L%0d post_rst_stale", L), got.size(), 0);
         // Mixed traffic with a randomly stalling consumer.
         fork
            begin
               for (int n = 0; n < 150; n++)
                  issue($urandom_range(0, 3) == 0, 8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)));
               stop = 1;
            end
            begin
               while (!stop) begin
                  rsp_ready = $urandom_range(0, 1) == 1;
                  step(1);
               end
            end
         join
         rsp_ready = 1;
         for (int t = 0; t < 50 && exp_q.size() != 0; t++) step(1);
         check($sformatf("L%0d drain", L), exp_q.size(), 0);
         fin = 1;
      end
   end
   initial begin
      wait (u[0].fin && u[1].fin);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
